pc_gen: RTL

Parametrised fetch program-counter generator for the RV32 core, replacing the fixed-width single-step PC register. It holds the fetch address, offers it to instruction memory with a valid/ready handshake, and advances by 2 or 4 bytes per accepted fetch. It applies trap and jump redirects by priority and detects misaligned jump targets, parking fetch until the trap path supplies a handler address.

---
 rtl/pc_gen.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// PcGen : fetch program-counter generator
//
// Holds the current fetch address and offers it to instruction memory with
// a valid/ready handshake. On each accepted fetch the address advances by
// 2 bytes (16-bit instruction, IALIGN==2 only) or 4 bytes. Trap and jump
// redirects replace the address with priority trap > jump > sequential.
// A jump whose target breaks 4-byte alignment parks fetch until the trap
// path supplies a handler address.
//
// Parameters
//   XLEN         address width
//   RESET_VECTOR pc loaded on reset (truncated / zero-extended to XLEN)
//   IALIGN       instruction alignment in bytes, 2 or 4
//
// Ports
//   clk          core clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   fetch_ready  instruction memory accepts the offered pc this cycle
//   inst_len_2   accepted instruction is 16-bit (ignored when IALIGN==4)
//   jump         jump / taken-branch redirect request
//   jump_target  raw ALU result for the jump
//   trap_valid   trap / exception redirect request
//   trap_target  trap handler address
//   pc           current fetch address
//   snpc         static next pc (pc + step), wraps modulo 2^XLEN
//   fetch_valid  pc is offered to instruction memory
//   misaligned   one-cycle pulse, a jump target broke alignment
//   bad_addr     offending jump target, held until the next event or reset
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter int          IALIGN       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_ready,
    input  logic            inst_len_2,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] snpc,
    output logic            fetch_valid,
    output logic            misaligned,
    output logic [XLEN-1:0] bad_addr
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        WAIT_TRAP = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] RESET_PC = XLEN'(RESET_VECTOR);

    // Mask that clears the low log2(IALIGN) bits of a trap handler address.
    localparam logic [XLEN-1:0] TRAP_MASK = ~XLEN'(IALIGN - 1);

    // Jump targets always lose bit 0, matching the JALR definition.
    localparam logic [XLEN-1:0] JUMP_MASK = ~XLEN'(1);

    state_t          state;
    logic [XLEN-1:0] step;
    logic [XLEN-1:0] jump_pc;
    logic [XLEN-1:0] trap_pc;
    logic            jump_bad;

    // Size of the instruction being fetched. Only a core built with
    // compressed support (IALIGN==2) can take a 2-byte step.
    always_comb begin
        step = XLEN'(4);
        if (IALIGN == 2 && inst_len_2) begin
            step = XLEN'(2);
        end
    end

    assign snpc = pc + step;

    // Redirect targets are cleaned up before use. Only a 4-byte aligned
    // core can see a bad jump target, since bit 0 is already dropped.
    assign jump_pc  = jump_target & JUMP_MASK;
    assign trap_pc  = trap_target & TRAP_MASK;
    assign jump_bad = (IALIGN == 4) && jump_pc[1];

    // The offer is a decode of the state register only, so no handshake or
    // redirect input can reach it combinationally.
    assign fetch_valid = (state == RUN);

    // Main sequencer. A trap is honoured from any state and always lands in
    // RUN. A jump is only acted on while fetching; a bad one parks fetch in
    // WAIT_TRAP with pc frozen so the faulting context is still visible.
    // Sequential advance requires an accepted offer, so pc never moves
    // under a pending offer except by a redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            misaligned <= 1'b0;
            bad_addr   <= '0;
        end else begin
            misaligned <= 1'b0;
            if (trap_valid) begin
                pc    <= trap_pc;
                state <= RUN;
            end else begin
                case (state)
                    IDLE: begin
                        state <= RUN;
                    end
                    RUN: begin
                        if (jump && jump_bad) begin
                            misaligned <= 1'b1;
                            bad_addr   <= jump_pc;
                            state      <= WAIT_TRAP;
                        end else if (jump) begin
                            pc <= jump_pc;
                        end else if (fetch_ready) begin
                            pc <= snpc;
                        end
                    end
                    WAIT_TRAP: begin
                        state <= WAIT_TRAP;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
